// File: rtl/dadda_multiplier_pipe.sv
// Pipelined WIDTH x WIDTH multiplier: Baugh-Wooley partial products, Dadda reduction,
// final carry-propagate add. Three stages share a single stall signal (advance).
module dadda_multiplier_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int PW = 2 * WIDTH;

  logic             advance;
  logic             s1_valid, s2_valid, s3_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_signed;
  logic [PW-1:0]    row0, row1, s2_row0, s2_row1;

  function automatic int dadda_height(input int idx);
    case (idx)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      4:       return 9;
      5:       return 13;
      6:       return 19;
      7:       return 28;
      default: return 42;
    endcase
  endfunction

  function automatic logic bit_at(input logic [PW-1:0] v, input int k);
    logic [PW-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Each column is a packed bit list filled from bit 0 upward; cnt tracks its height.
  // Carries produced in a stage join the next column's pool in that same stage.
  always_comb begin : reduce_tree
    logic [PW-1:0] col  [PW];
    logic [PW-1:0] nxt  [PW];
    logic [PW-1:0] cin  [PW];
    int            cnt  [PW];
    int            ncnt [PW];
    int            ccnt [PW];
    logic [PW-1:0] pool;
    int            np, p, h, d;
    logic          x, y, z, pp, sum, carry;

    for (int c = 0; c < PW; c++) begin
      col[c] = '0; nxt[c] = '0; cin[c] = '0;
      cnt[c] = 0;  ncnt[c] = 0; ccnt[c] = 0;
    end
    pool = '0; np = 0; p = 0; h = 0; d = 0;
    x = 1'b0; y = 1'b0; z = 1'b0; pp = 1'b0; sum = 1'b0; carry = 1'b0;
    row0 = '0; row1 = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = s1_a[j] & s1_b[i];
        if ((i == WIDTH - 1) != (j == WIDTH - 1)) pp = pp ^ s1_signed;
        col[i+j] = col[i+j] | (PW'(pp) << cnt[i+j]);
        cnt[i+j] = cnt[i+j] + 1;
      end
    end
    // Signed correction: +2^WIDTH and +2^(2*WIDTH-1); zero bits in unsigned mode.
    col[WIDTH] = col[WIDTH] | (PW'(s1_signed) << cnt[WIDTH]);
    cnt[WIDTH] = cnt[WIDTH] + 1;
    col[PW-1]  = col[PW-1] | (PW'(s1_signed) << cnt[PW-1]);
    cnt[PW-1]  = cnt[PW-1] + 1;

    for (int s = 7; s >= 0; s--) begin
      d = dadda_height(s);
      if (d < WIDTH) begin
        for (int c = 0; c < PW; c++) begin
          nxt[c] = '0; cin[c] = '0; ncnt[c] = 0; ccnt[c] = 0;
        end
        for (int c = 0; c < PW; c++) begin
          pool = cin[c] | (col[c] << ccnt[c]);
          np   = ccnt[c] + cnt[c];
          h    = np;
          p    = 0;
          for (int k = 0; k < PW; k++) begin
            if (h > d) begin
              x = bit_at(pool, p);
              y = bit_at(pool, p + 1);
              if (h - d >= 2) begin
                z     = bit_at(pool, p + 2);
                sum   = x ^ y ^ z;
                carry = (x & y) | (x & z) | (y & z);
                p     = p + 3;
                h     = h - 2;
              end else begin
                sum   = x ^ y;
                carry = x & y;
                p     = p + 2;
                h     = h - 1;
              end
              nxt[c]  = nxt[c] | (PW'(sum) << ncnt[c]);
              ncnt[c] = ncnt[c] + 1;
              if (c < PW - 1) begin
                cin[(c + 1) % PW]  = cin[(c + 1) % PW] | (PW'(carry) << ccnt[(c + 1) % PW]);
                ccnt[(c + 1) % PW] = ccnt[(c + 1) % PW] + 1;
              end
            end
          end
          nxt[c]  = nxt[c] | ((pool >> p) << ncnt[c]);
          ncnt[c] = ncnt[c] + (np - p);
        end
        for (int c = 0; c < PW; c++) begin
          col[c] = nxt[c];
          cnt[c] = ncnt[c];
        end
      end
    end

    for (int c = 0; c < PW; c++) begin
      row0 = row0 | (PW'(col[c][0]) << c);
      row1 = row1 | (PW'(col[c][1]) << c);
    end
  end

  assign advance   = !s3_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_valid;
  assign busy      = s1_valid | s2_valid | s3_valid;

  // Whole pipeline moves in lockstep; data registers only load behind a valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_signed <= 1'b0;
      s2_row0   <= '0;
      s2_row1   <= '0;
      product   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_signed <= signed_mode;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_row0 <= row0;
        s2_row1 <= row1;
      end
      s3_valid <= s2_valid;
      if (s2_valid) product <= s2_row0 + s2_row1;
    end
  end
endmodule
